// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one 63-bit add/sub ALU across NREQ requesters; ALU_STATS_EN adds op/stall counters.
// Latency accept->rsp_valid is 2 cycles; a stalled response holds, then the issue stage fills, then req_ready drops to 0.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*63-1:0]   req_a,
  input  logic [NREQ*63-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [62:0]          alu_a,
  output logic [62:0]          alu_b,
  output logic [3:0]           alu_opcode,
  input  logic [63:0]          alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_data
`ifdef ALU_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
`endif
);

  typedef struct packed {
    logic [62:0]    a;
    logic [62:0]    b;
    logic [3:0]     op;
    logic [IDW-1:0] id;
  } hdr_t;

  logic           res_free;
  logic           issue_free;
  logic           accept;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  hdr_t           grant_hdr;

  hdr_t           issue_q, issue_d;
  logic           issue_v_q, issue_v_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [63:0]    rsp_data_q, rsp_data_d;

  assign res_free   = !rsp_valid_q || rsp_ready;
  assign issue_free = !issue_v_q || res_free;

  // Two passes give the wrap-around search: indices at/above rr_ptr first, then below it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) < rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && issue_free && grant_found && (grant_idx == IDW'(i));
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    grant_hdr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_hdr.a  = req_a[63*i +: 63];
        grant_hdr.b  = req_b[63*i +: 63];
        grant_hdr.op = req_op[4*i +: 4];
        grant_hdr.id = IDW'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_comb begin
    issue_d   = issue_q;
    issue_v_d = issue_v_q;
    if (accept) begin
      issue_d   = grant_hdr;
      issue_v_d = 1'b1;
    end else if (issue_free) begin
      issue_v_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (issue_v_q && res_free) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = issue_q.id;
      rsp_data_d  = alu_result;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q     <= '0;
      issue_v_q   <= 1'b0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      issue_q     <= issue_d;
      issue_v_q   <= issue_v_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign alu_a      = issue_q.a;
  assign alu_b      = issue_q.b;
  assign alu_opcode = issue_q.op;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

`ifdef ALU_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (stat_clr) begin
      stat_ops_d   = '0;
      stat_stall_d = '0;
    end else begin
      if (rsp_valid_q && rsp_ready) stat_ops_d = stat_ops_q + 32'd1;
      if ((|req_valid) && !accept) stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: queue-based reference of the two-slot pipeline plus round-robin pick.
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*63-1:0]  req_a;
  logic [NREQ*63-1:0]  req_b;
  logic [NREQ*4-1:0]   req_op;
  logic [62:0]         alu_a;
  logic [62:0]         alu_b;
  logic [3:0]          alu_opcode;
  logic [63:0]         alu_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [63:0]         rsp_data;
`ifdef ALU_STATS_EN
  logic                stat_clr;
  logic [31:0]         stat_ops;
  logic [31:0]         stat_stall;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [62:0] a;
    logic [62:0] b;
    logic [3:0]  op;
    int          id;
    bit          at_rsp;
  } ent_t;

  ent_t        pipe[$];
  int          rr;
  int unsigned m_ops;
  int unsigned m_stall;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef ALU_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`endif
  );

  function automatic logic [63:0] alu_fn(input logic [62:0] a, input logic [62:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b1000: return {1'b0, a} - {1'b0, b};
      default: return 64'd0;
    endcase
  endfunction

  // Stand-in for the external combinational ALU.
  always_comb alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [62:0] a, input logic [62:0] b, input logic [3:0] op);
    req_a[63*i +: 63] = a;
    req_b[63*i +: 63] = b;
    req_op[4*i +: 4]  = op;
  endtask

  task automatic model_reset();
    pipe.delete();
    rr      = 0;
    m_ops   = 0;
    m_stall = 0;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model across the edge.
  task automatic cycle();
    ent_t            e;
    int              win;
    bit              pop;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    if (pipe.size() > 0 && pipe[0].at_rsp) begin
      e = pipe[0];
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(e.id));
      chk("rsp_data", rsp_data, alu_fn(e.a, e.b, e.op));
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'd0);
    end
    if (pipe.size() > 0 && !pipe[pipe.size()-1].at_rsp) begin
      e = pipe[pipe.size()-1];
      chk("alu_a", 64'(alu_a), 64'(e.a));
      chk("alu_b", 64'(alu_b), 64'(e.b));
      chk("alu_opcode", 64'(alu_opcode), 64'(e.op));
    end
`ifdef ALU_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'(m_ops));
    chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    pop = (pipe.size() > 0) && pipe[0].at_rsp && rsp_ready;
    if (pop) void'(pipe.pop_front());
    if (pipe.size() > 0 && !pipe[0].at_rsp) begin
      e = pipe[0];
      e.at_rsp = 1'b1;
      pipe[0] = e;
    end
    win = -1;
    if (pipe.size() == 0 || pipe[pipe.size()-1].at_rsp) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && req_valid[(rr + k) % NREQ]) win = (rr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (win >= 0) begin
      e.a = req_a[63*win +: 63];
      e.b = req_b[63*win +: 63];
      e.op = req_op[4*win +: 4];
      e.id = win;
      e.at_rsp = 1'b0;
      pipe.push_back(e);
      rr = (win + 1) % NREQ;
    end
`ifdef ALU_STATS_EN
    if (stat_clr) begin
      m_ops   = 0;
      m_stall = 0;
    end else begin
      if (pop) m_ops++;
      if ((|req_valid) && win < 0) m_stall++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_opcode), 64'd0);
  endtask

  initial begin
    logic [62:0] ra;
    logic [62:0] rb;
    logic [3:0]  rop;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
`ifdef ALU_STATS_EN
    stat_clr  = 1'b0;
`endif
    model_reset();

    @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // Carry out of 63-bit add lands in bit 63.
    drive(2, 63'h7FFF_FFFF_FFFF_FFFF, 63'd1, 4'b0000);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    chk("add_carry_valid", 64'(rsp_valid), 64'd1);
    chk("add_carry_id", 64'(rsp_id), 64'd2);
    chk("add_carry_data", rsp_data, 64'h8000_0000_0000_0000);
    cycle();

    // Subtract borrow, then an unsupported opcode.
    drive(0, 63'd5, 63'd7, 4'b1000);
    req_valid = 4'b0001;
    cycle();
    drive(0, 63'd5, 63'd7, 4'b0101);
    cycle();
    req_valid = '0;
    chk("sub_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle();
    chk("badop_data", rsp_data, 64'd0);
    cycle();

    // Round-robin rotation with all requesters, then with requester 1 dropped.
    for (int i = 0; i < NREQ; i++) drive(i, 63'(100 + i), 63'(i), 4'b0000);
    req_valid = 4'b1111;
    repeat (10) cycle();
    req_valid = 4'b1101;
    repeat (8) cycle();

    // Response stall: two accepts fill the pipe, then grants stop until release.
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (4) cycle();
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) cycle();

    // Asynchronous reset while both stages hold operations.
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    model_reset();
    #9;
    chk_zero_outputs("midrst_hold");
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'b0010);
    repeat (4) cycle();
    req_valid = '0;
    repeat (3) cycle();

`ifdef ALU_STATS_EN
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    req_valid = 4'b0001;
    repeat (10) cycle();
    req_valid = '0;
    repeat (2) cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (5) cycle();
    req_valid = '0;
    chk("stats_ops10", 64'(stat_ops), 64'd10);
    chk("stats_stall3", 64'(stat_stall), 64'd3);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    chk("stats_clr_ops", 64'(stat_ops), 64'd0);
    chk("stats_clr_stall", 64'(stat_stall), 64'd0);
    rsp_ready = 1'b1;
    repeat (3) cycle();
`endif

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        ra = 63'({$urandom, $urandom});
        rb = 63'({$urandom, $urandom});
        if ($urandom_range(0, 7) == 0) ra = '1;
        if ($urandom_range(0, 7) == 0) rb = '1;
        case ($urandom_range(0, 3))
          0: rop = 4'b0000;
          1: rop = 4'b1000;
          default: rop = 4'($urandom);
        endcase
        drive(i, ra, rb, rop);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_STATS_EN
      stat_clr = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
`ifdef ALU_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
